// File: rtl/axi_lite_sram_responder.sv
// AXI4-Lite responder over a word-addressed on-chip array with fixed read/write latency.
// Read and write channels are independent and each holds one transaction at a time.
module axi_lite_sram_responder #(
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h8000_0000,
  parameter int                RD_LAT      = 2,
  parameter int                WR_LAT      = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int              IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] SPAN    = (ADDR_W + 1)'(DEPTH_WORDS) << 2;
  localparam logic [3:0]      RD_LOAD = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);
  localparam logic [3:0]      WR_LOAD = (WR_LAT == 0) ? 4'd0 : 4'(WR_LAT - 1);
  localparam logic [1:0]      OKAY    = 2'b00;
  localparam logic [1:0]      SLVERR  = 2'b10;

  if (RD_LAT < 0 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("RD_LAT must be in 0..15");
  end
  if (WR_LAT < 0 || WR_LAT > 15) begin : g_bad_wr_lat
    $error("WR_LAT must be in 0..15");
  end

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
    return (a >= BASE_ADDR) && (({1'b0, a} - {1'b0, BASE_ADDR}) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // ---------------- read channel ----------------
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  r_state_t          r_state;
  logic [3:0]        rd_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_sel;
  logic              rd_sample;

  // With zero latency the array is sampled on the AR handshake edge itself.
  assign rd_sel    = (r_state == R_IDLE) ? araddr : rd_addr;
  assign rd_sample = ((r_state == R_IDLE) && arvalid && (RD_LAT == 0)) ||
                     ((r_state == R_WAIT) && (rd_cnt == 4'd0));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
      rd_cnt  <= '0;
      rd_addr <= '0;
    end else begin
      if (rd_sample) begin
        rdata   <= addr_hit(rd_sel) ? mem[addr_index(rd_sel)] : '0;
        rresp   <= addr_hit(rd_sel) ? OKAY : SLVERR;
        rvalid  <= 1'b1;
        r_state <= R_RESP;
      end
      unique case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            rd_addr <= araddr;
            arready <= 1'b0;
            if (RD_LAT != 0) begin
              rd_cnt  <= RD_LOAD;
              r_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (rd_cnt != 4'd0) rd_cnt <= rd_cnt - 4'd1;
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  w_state_t          w_state;
  logic [3:0]        wr_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              have_aw, have_w;
  logic [ADDR_W-1:0] wr_addr_eff;
  logic [31:0]       wr_data_eff;
  logic [3:0]        wr_strb_eff;
  logic              wr_fire, wr_hit, wr_commit;

  // A ready that is still high means that half has not been captured yet.
  assign have_aw     = !awready || awvalid;
  assign have_w      = !wready  || wvalid;
  assign wr_addr_eff = awready ? awaddr : wr_addr;
  assign wr_data_eff = wready  ? wdata  : wr_data;
  assign wr_strb_eff = wready  ? wstrb  : wr_strb;
  assign wr_hit      = addr_hit(wr_addr_eff);
  assign wr_fire     = ((w_state == W_IDLE) && have_aw && have_w && (WR_LAT == 0)) ||
                       ((w_state == W_WAIT) && (wr_cnt == 4'd0));
  assign wr_commit   = !reset && wr_fire && wr_hit;

  always_ff @(posedge clock) begin
    if (wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_eff[b]) mem[addr_index(wr_addr_eff)][b*8 +: 8] <= wr_data_eff[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b1;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      wr_cnt  <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_strb <= '0;
    end else begin
      if (wr_fire) begin
        bresp   <= wr_hit ? OKAY : SLVERR;
        bvalid  <= 1'b1;
        w_state <= W_RESP;
      end
      unique case (w_state)
        W_IDLE: begin
          if (awready && awvalid) begin
            wr_addr <= awaddr;
            awready <= 1'b0;
          end
          if (wready && wvalid) begin
            wr_data <= wdata;
            wr_strb <= wstrb;
            wready  <= 1'b0;
          end
          if (have_aw && have_w && (WR_LAT != 0)) begin
            wr_cnt  <= WR_LOAD;
            w_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wr_cnt != 4'd0) wr_cnt <= wr_cnt - 4'd1;
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule
